// File: rtl/vector_checker.sv
// vector_checker: sweeps every input combination onto a small combinational
// DUT, samples its output after SETTLE cycles and checks it against TRUTH.
// Optional feature macro: VECCHK_STOP_ON_ERR_EN (halt on first mismatch).
module vector_checker #(
  parameter int                      N_IN   = 3,
  parameter logic [(2**N_IN)-1:0]    TRUTH  = 8'h39,
  parameter int                      SETTLE = 1,
  parameter int                      ERR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [N_IN-1:0]   vec,
  input  logic              dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_valid,
  output logic [N_IN-1:0]   err_vec,
  output logic              err_got
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [N_IN-1:0] LAST      = '1;
  localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);

`ifdef VECCHK_STOP_ON_ERR_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  state_t           state;
  logic [3:0]       settle;
  logic             miss;
  logic             stop;
  logic [ERR_W-1:0] cnt_inc;

  // Mismatch detect and saturating increment of the error count
  always_comb begin
    miss    = (dut_y != TRUTH[vec]);
    stop    = STOP_EN && miss;
    cnt_inc = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);
  end

  // Sweep FSM: vec doubles as the vector index and is held through DRIVE+CHECK
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      settle    <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      err_valid <= 1'b0;
      err_vec   <= '0;
      err_got   <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_DRIVE;
            settle  <= '0;
            vec     <= '0;
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (settle == SETTLE_M1) begin
            state <= S_CHECK;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        S_CHECK: begin
          settle <= '0;
          if (miss) begin
            err_valid <= 1'b1;
            err_vec   <= vec;
            err_got   <= dut_y;
            err_cnt   <= cnt_inc;
          end
          if (vec == LAST || stop) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !miss && (err_cnt == '0);
          end else begin
            vec   <= vec + N_IN'(1);
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: directed sweeps against behavioural DUT variants,
// error pulses and done summaries checked through a scoreboard.
module tb_vector_checker;

  typedef struct {
    logic [2:0] v;
    logic       g;
  } err_t;

  typedef struct {
    int         cnt;
    logic       p;
    logic [2:0] v;
    logic       g;
  } done_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  vec;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] err_cnt;
  logic        err_valid;
  logic [2:0]  err_vec;
  logic        err_got;

  logic [7:0]  model_tab = 8'h39;
  int          applied = 0;
  int          miscompares = 0;
  err_t        err_q[$];
  done_t       done_q[$];
  logic [2:0]  last_ev = '0;
  logic        last_eg = 1'b0;
  logic        done_prev = 1'b0;

  always #5 clk = ~clk;

  assign dut_y = model_tab[vec];

  vector_checker dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vec       (vec),
    .dut_y     (dut_y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .err_valid (err_valid),
    .err_vec   (err_vec),
    .err_got   (err_got)
  );

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT reports an error or finishes
  always @(negedge clk) begin
    if (err_valid) begin
      if (err_q.size() == 0) begin
        chk("unexpected err_valid at vec", int'(err_vec), -1);
      end else begin
        err_t e;
        e = err_q.pop_front();
        chk("err_vec", int'(err_vec), int'(e.v));
        chk("err_got", int'(err_got), int'(e.g));
      end
    end
    if (done && !done_prev) begin
      if (done_q.size() == 0) begin
        chk("unexpected done", 1, 0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        chk("err_cnt at done", int'(err_cnt), d.cnt);
        chk("pass at done", int'(pass), int'(d.p));
        chk("err_vec at done", int'(err_vec), int'(d.v));
        chk("err_got at done", int'(err_got), int'(d.g));
        chk("missing err pulses", err_q.size(), 0);
      end
    end
    done_prev <= done;
  end

  task automatic check_zero(input string tag);
    chk({tag, " vec"}, int'(vec), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " pass"}, int'(pass), 0);
    chk({tag, " err_cnt"}, int'(err_cnt), 0);
    chk({tag, " err_valid"}, int'(err_valid), 0);
    chk({tag, " err_vec"}, int'(err_vec), 0);
    chk({tag, " err_got"}, int'(err_got), 0);
  endtask

  // One sweep: mask = failing vectors, got = DUT value at those vectors
  task automatic sweep(input logic [7:0] mask, input logic [7:0] got,
                       input bit poke);
    int n = 0;
    int last = 7;
    int cyc;
    int bcyc = 0;
    done_t d;
    for (int v = 0; v < 8; v++) begin
      if (mask[v]) begin
`ifdef VECCHK_STOP_ON_ERR_EN
        if (n == 0) last = v;
        if (n > 0) continue;
`endif
        err_q.push_back('{3'(v), got[v]});
        n++;
        last_ev = 3'(v);
        last_eg = got[v];
      end
    end
    d = '{n, (n == 0), last_ev, last_eg};
    done_q.push_back(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("err_cnt after start", int'(err_cnt), 0);
    chk("done after start", int'(done), 0);
    chk("busy after start", int'(busy), 1);
    while (cyc < 100 && !done) begin
      if (busy) begin
        bcyc++;
        chk("vec step", int'(vec), (cyc - 1) / 2);
      end
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 4 || cyc == 9);
    end
    start = 1'b0;
    chk("sweep timeout", int'(done), 1);
    chk("done cycle", cyc, 2 * (last + 1) + 1);
    chk("busy cycles", bcyc, 2 * (last + 1));
    chk("busy at done", int'(busy), 0);
    chk("vec at done", int'(vec), last);
    @(negedge clk);
    chk("done held", int'(done), 1);
  endtask

  initial begin
    int w;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    model_tab = 8'h39;
    sweep(8'h00, 8'h00, 1'b0);

    model_tab = 8'h00;
    sweep(8'h39, 8'h00, 1'b0);

    model_tab = 8'hC6;
    sweep(8'hFF, 8'hC6, 1'b0);
    sweep(8'hFF, 8'hC6, 1'b0);

    model_tab = 8'h79;
    sweep(8'h40, 8'h40, 1'b0);

    model_tab = 8'h39;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (vec != 3'd3 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("reach vec 3", int'(vec), 3);
    reset = 1'b0;
    @(negedge clk);
    check_zero("mid-sweep reset");
    reset = 1'b1;
    err_q.delete();
    done_q.delete();
    last_ev = '0;
    last_eg = 1'b0;
    @(negedge clk);
    sweep(8'h00, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
